oled_spi_arbiter: RTL

- Shares the single OLED SPI byte engine (1 MHz domain) between NREQ byte sources: init sequencer, RAM refresh reader, runtime command source (contrast/scroll/power).
- Round-robin arbitration per byte, with a burst lock so a multi-byte command/data sequence is never interleaved.
- Owns the engine's enable and dc inputs, routes write completion back as a per-requester ack, and flags a hung engine via timeout.

---
 rtl/oled_pkg.sv | 17 +
 rtl/oled_rr_pick.sv | 33 +++
 rtl/oled_spi_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI arbiter slice: FSM states, dc encoding,
// byte width and default engine timeout.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic DC_CMD      = 1'b0;
  localparam logic DC_DATA     = 1'b1;
  localparam int   BYTE_W      = 8;
  localparam int   TIMEOUT_DEF = 64;

endpackage

// File: rtl/oled_rr_pick.sv
// Rotating-priority picker: the first set request scanning upward from
// ptr+1 (with wrap) wins. Purely combinational.
module oled_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          hit_s;

  // Walk the requesters in rotated order and latch onto the first one set.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum_s  = '0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s  = {1'b0, ptr} + (PW+1)'(i + 1);
      idx_s  = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);
      hit_s  = req[idx_s] & ~valid;
      winner[idx_s] = winner[idx_s] | hit_s;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one OLED SPI byte engine between NREQ byte sources. Round-robin per
// byte, burst lock holds ownership across a multi-byte sequence, per-requester
// ack on completion and a sticky timeout flag for a hung engine.
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [BYTE_W*NREQ-1:0] wdata,
  input  logic [NREQ-1:0]        wdc,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        gnt,
  output logic                   spi_ena,
  output logic [BYTE_W-1:0]      spi_data,
  output logic                   spi_dc,
  input  logic                   spi_done,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t              state_r;
  logic [TW-1:0]       timer_r;
  logic [PW-1:0]       ptr_r;
  logic [NREQ-1:0]     winner_s;
  logic                valid_s;
  logic [PW-1:0]       win_idx_s;
  logic [PW-1:0]       load_idx_s;
  logic [BYTE_W-1:0]   bytes_s [NREQ];

  oled_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Unpack the byte bus, encode the winner index and choose the load source
  // (fresh winner from IDLE, current owner from HOLD).
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      bytes_s[i] = wdata[i*BYTE_W +: BYTE_W];
      win_idx_s  = win_idx_s | (winner_s[i] ? PW'(i) : PW'(0));
    end
    load_idx_s = (state_r == HOLD) ? ptr_r : win_idx_s;
  end

  // Arbitration FSM with timer, sticky error and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      ptr_r       <= PW'(NREQ - 1);
      ack         <= '0;
      gnt         <= '0;
      spi_ena     <= 1'b0;
      spi_data    <= '0;
      spi_dc      <= DC_CMD;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      spi_ena <= 1'b0;
      ack     <= '0;
      // A timeout set later in this block overrides the clear.
      if (clr_err) begin
        timeout_err <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            gnt      <= NREQ'(1) << load_idx_s;
            spi_data <= bytes_s[load_idx_s];
            spi_dc   <= wdc[load_idx_s];
            ptr_r    <= load_idx_s;
            busy     <= 1'b1;
            state_r  <= SEND;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        SEND: begin
          spi_ena <= 1'b1;
          timer_r <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            ack <= NREQ'(1) << ptr_r;
            if (lock[ptr_r]) begin
              state_r <= HOLD;
            end else begin
              gnt     <= '0;
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end else if (timer_r == TMAX) begin
            timeout_err <= 1'b1;
            gnt         <= '0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        HOLD: begin
          if (req[ptr_r]) begin
            gnt      <= NREQ'(1) << load_idx_s;
            spi_data <= bytes_s[load_idx_s];
            spi_dc   <= wdc[load_idx_s];
            ptr_r    <= load_idx_s;
            state_r  <= SEND;
          end else if (!lock[ptr_r]) begin
            gnt     <= '0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
